alsu_input_conditioner: RTL

Front-end stage directly upstream of the ALSU on the board build. It synchronises and debounces the raw slide switches and a load push-button, then presents a clean, stable operand/control bundle to the ALSU input ports. In latch mode the bundle only changes on a debounced load press, so the operator can set up all switches before committing a new operation.

---
 rtl/alsu_input_conditioner.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alsu_input_conditioner.sv
// Synchronises and debounces ALSU switch and load-button inputs.
// Drives a stable operand/control bundle, optionally latched on load.
module alsu_input_debounce #(
  parameter int W = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  chain [SYNC_STAGES];
  logic [W-1:0]  prev;
  logic [CW-1:0] cnt;
  logic [W-1:0]  s;

  assign s = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev <= '0;
      cnt  <= '0;
      db   <= '0;
    end else begin
      chain[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= s;
      // still bouncing or already accepted: restart the hold count
      if (s == db) begin
        cnt <= '0;
      end else if (s != prev) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module alsu_input_conditioner #(
  parameter int    DEBOUNCE_CYCLES = 1000000,
  parameter int    SYNC_STAGES = 2,
  parameter string LATCH_MODE = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sw,
  input  logic        btn_load,
  output logic [2:0]  A,
  output logic [2:0]  B,
  output logic [2:0]  opcode,
  output logic        cin,
  output logic        serial_in,
  output logic        red_op_A,
  output logic        red_op_B,
  output logic        bypass_A,
  output logic        bypass_B,
  output logic        direction,
  output logic        load_pulse,
  output logic        pending
);
  localparam bit LATCH = (LATCH_MODE == "ON");

  logic [17:0] sw_db;
  logic        btn_db;
  logic        btn_db_d;
  logic [15:0] cur;
  logic        unused_sw;

  alsu_input_debounce #(
    .W(18),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sw_db (
    .clk(clk),
    .rst(rst),
    .raw(sw),
    .db(sw_db)
  );

  alsu_input_debounce #(
    .W(1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn_db (
    .clk(clk),
    .rst(rst),
    .raw(btn_load),
    .db(btn_db)
  );

  assign unused_sw = ^sw_db[17:16];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db_d   <= 1'b0;
      load_pulse <= 1'b0;
      cur        <= '0;
      pending    <= 1'b0;
    end else begin
      btn_db_d   <= btn_db;
      load_pulse <= btn_db & ~btn_db_d;
      if (!LATCH || load_pulse) cur <= sw_db[15:0];
      pending    <= (sw_db[15:0] != cur);
    end
  end

  assign A         = cur[2:0];
  assign B         = cur[5:3];
  assign opcode    = cur[8:6];
  assign cin       = cur[9];
  assign serial_in = cur[10];
  assign red_op_A  = cur[11];
  assign red_op_B  = cur[12];
  assign bypass_A  = cur[13];
  assign bypass_B  = cur[14];
  assign direction = cur[15];
endmodule
